// File: rtl/bist_pkg.sv
// ---------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the BIST signature analyzer: the controller state
// encoding and the width of the response counter.
// No ports (package).
// ---------------------------------------------------------------------------
package bist_pkg;

    // Width of the response counter and of num_patterns.
    localparam int COUNT_W = 16;

    typedef logic [COUNT_W-1:0] count_t;

    // Controller states. Plain constants keep the encoding visible to older
    // tools and to anyone probing the state register in a waveform.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

endpackage

// File: rtl/misr_core.sv
// ---------------------------------------------------------------------------
// misr_core
// Combinational next-state function of an n-bit multiple-input signature
// register. The register shifts toward bit 0, bit 0 is fed back into every
// stage whose poly bit is set, and the response word is folded in on top.
//
// Ports:
//   sig      in  n  current signature
//   poly     in  n  feedback tap mask (top bit is implied; the top stage
//                   always receives sig[0])
//   resp     in  n  response word to fold in
//   sig_next out n  signature after absorbing resp
// ---------------------------------------------------------------------------
module misr_core #(
    parameter int n = 8
) (
    input  logic [n-1:0] sig,
    input  logic [n-1:0] poly,
    input  logic [n-1:0] resp,
    output logic [n-1:0] sig_next
);

    // The top stage is always a feedback stage, so poly[n-1] carries no
    // information; it is parked here to show it is deliberately unused.
    logic unusedPolyMsb;
    assign unusedPolyMsb = poly[n-1];

    // Each lower stage takes its upper neighbour, the gated feedback bit and
    // its own response bit; the top stage takes feedback plus response only.
    always_comb begin
        sig_next = '0;
        for (int i = 0; i < n - 1; i++) begin
            sig_next[i] = (sig[0] & poly[i]) ^ sig[i+1] ^ resp[i];
        end
        sig_next[n-1] = sig[0] ^ resp[n-1];
    end

endmodule

// File: rtl/bist_signature_analyzer.sv
// ---------------------------------------------------------------------------
// bist_signature_analyzer
// Compacts a stream of circuit-under-test responses into a MISR signature,
// then compares the final signature against a golden value.
//
// Ports:
//   clk          in  1   clock, all state changes on rising edge
//   rst          in  1   synchronous active-high reset
//   start        in  1   begin a run (honoured only in IDLE or DONE)
//   num_patterns in  16  responses to compact, captured on start
//   seed         in  n   initial signature, captured on start
//   poly         in  n   feedback tap mask, held stable during a run
//   golden       in  n   expected signature, sampled in CHECK
//   resp_valid   in  1   resp holds a response this cycle
//   resp         in  n   response word
//   busy         out 1   high in RUN and CHECK
//   done         out 1   high in DONE
//   pass         out 1   signature matched golden (valid while done=1)
//   signature    out n   current MISR contents
// ---------------------------------------------------------------------------
module bist_signature_analyzer
    import bist_pkg::*;
#(
    parameter int n = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] num_patterns,
    input  logic [n-1:0]       seed,
    input  logic [n-1:0]       poly,
    input  logic [n-1:0]       golden,
    input  logic               resp_valid,
    input  logic [n-1:0]       resp,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [n-1:0]       signature
);

    logic [1:0] state;
    count_t     count;
    count_t     numReg;
    logic [n-1:0] sigReg;
    logic [n-1:0] sigNext;
    logic       passReg;

    misr_core #(
        .n(n)
    ) u_misr (
        .sig      (sigReg),
        .poly     (poly),
        .resp     (resp),
        .sig_next (sigNext)
    );

    // Controller, response counter and signature register. The run ends on
    // the edge that absorbs response number num_patterns-1 (counting from
    // zero), so the counter never has to hold num_patterns itself and a
    // run of 16'hFFFF responses never wraps before the terminal compare.
    // A zero-length run skips RUN entirely and compares the seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            numReg  <= '0;
            sigReg  <= '0;
            passReg <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sigReg  <= seed;
                        count   <= '0;
                        numReg  <= num_patterns;
                        passReg <= 1'b0;
                        state   <= (num_patterns == '0) ? CHECK : RUN;
                    end
                end
                RUN: begin
                    if (resp_valid) begin
                        sigReg <= sigNext;
                        count  <= count + count_t'(1);
                        if (count == numReg - count_t'(1)) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    passReg <= (sigReg == golden);
                    state   <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status outputs are pure decodes of the state register.
    always_comb begin
        busy      = (state == RUN) || (state == CHECK);
        done      = (state == DONE);
        pass      = passReg;
        signature = sigReg;
    end

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// ---------------------------------------------------------------------------
// tb_bist_signature_analyzer
// Self-checking bench for bist_signature_analyzer (n=8). A behavioural model
// tracks the expected phase, signature and pass flag; a compare process
// checks the DUT against it every cycle, and directed cases pin literal
// values.
// ---------------------------------------------------------------------------
module tb_bist_signature_analyzer;

    localparam int N = 8;

    localparam int PH_IDLE  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_CHECK = 2;
    localparam int PH_DONE  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   num_patterns;
    logic [N-1:0]  seed;
    logic [N-1:0]  poly;
    logic [N-1:0]  golden;
    logic          resp_valid;
    logic [N-1:0]  resp;
    logic          busy;
    logic          done;
    logic          pass;
    logic [N-1:0]  signature;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int           mPhase = PH_IDLE;
    logic [N-1:0] mSig   = '0;
    logic         mPass  = 1'b0;
    int           mAbsorbed = 0;
    int           mTarget   = 0;
    bit           checkEnable = 1'b0;

    always #5 clk = ~clk;

    bist_signature_analyzer #(
        .n(N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_patterns (num_patterns),
        .seed         (seed),
        .poly         (poly),
        .golden       (golden),
        .resp_valid   (resp_valid),
        .resp         (resp),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature)
    );

    // Signature update written as a right shift with a Galois feedback word;
    // the top feedback bit is always present.
    function automatic logic [N-1:0] modelMisr(input logic [N-1:0] s,
                                               input logic [N-1:0] p,
                                               input logic [N-1:0] r);
        logic [N-1:0] fb;
        fb = p;
        fb[N-1] = 1'b1;
        return (s >> 1) ^ (s[0] ? fb : '0) ^ r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on every rising edge using the inputs the DUT sees.
    always @(posedge clk) begin
        if (rst) begin
            mPhase = PH_IDLE;
            mSig = '0;
            mPass = 1'b0;
            mAbsorbed = 0;
        end else if ((mPhase == PH_IDLE || mPhase == PH_DONE) && start) begin
            mSig = seed;
            mPass = 1'b0;
            mAbsorbed = 0;
            mTarget = int'(num_patterns);
            mPhase = (mTarget == 0) ? PH_CHECK : PH_RUN;
        end else if (mPhase == PH_RUN && resp_valid) begin
            mSig = modelMisr(mSig, poly, resp);
            mAbsorbed++;
            if (mAbsorbed == mTarget) mPhase = PH_CHECK;
        end else if (mPhase == PH_CHECK) begin
            mPass = (mSig == golden);
            mPhase = PH_DONE;
        end
    end

    // Every falling edge the DUT outputs are compared with the model.
    always @(negedge clk) begin
        if (checkEnable) begin
            checkOutput("busy", 32'(busy), 32'(mPhase == PH_RUN || mPhase == PH_CHECK));
            checkOutput("done", 32'(done), 32'(mPhase == PH_DONE));
            checkOutput("signature", 32'(signature), 32'(mSig));
            if (mPhase == PH_DONE) checkOutput("pass", 32'(pass), 32'(mPass));
        end
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [N-1:0] s, input logic [N-1:0] p,
                                 input logic [15:0] num, input logic [N-1:0] g);
        seed = s;
        poly = p;
        num_patterns = num;
        golden = g;
        start = 1'b1;
        cycle();
        start = 1'b0;
        seed = N'($urandom);
        num_patterns = 16'($urandom);
    endtask

    task automatic sendResp(input logic [N-1:0] r);
        resp = r;
        resp_valid = 1'b1;
        cycle();
        resp_valid = 1'b0;
        resp = N'($urandom);
    endtask

    task automatic waitDone(input int bound);
        int k = 0;
        while (!done && k < bound) begin
            cycle();
            k++;
        end
        if (!done) checkOutput("doneTimeout", 32'(done), 32'd1);
    endtask

    logic [N-1:0] respList[$];

    initial begin
        logic [N-1:0] s, p, g, fin;
        int num;
        bit wantPass;

        rst = 1'b1; start = 1'b0; resp_valid = 1'b0;
        num_patterns = '0; seed = '0; poly = '0; golden = '0; resp = '0;
        cycle();
        cycle();
        checkEnable = 1'b1;
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetPass", 32'(pass), 32'd0);
        checkOutput("resetSig", 32'(signature), 32'd0);
        rst = 1'b0;
        cycle();

        // Rotate-and-seed with exact two-cycle latency
        applyStimulus(8'h01, 8'h00, 16'd1, 8'h80);
        sendResp(8'h00);
        checkOutput("latCheckBusy", 32'(busy), 32'd1);
        checkOutput("latCheckDone", 32'(done), 32'd0);
        cycle();
        checkOutput("latDone", 32'(done), 32'd1);
        checkOutput("rotateSig", 32'(signature), 32'h80);
        checkOutput("rotatePass", 32'(pass), 32'd1);

        // Feedback taps
        applyStimulus(8'h01, 8'hB8, 16'd1, 8'hB8);
        sendResp(8'h00);
        waitDone(4);
        checkOutput("tapsSig", 32'(signature), 32'hB8);
        checkOutput("tapsPass", 32'(pass), 32'd1);

        // Folding with a stall
        applyStimulus(8'h00, 8'h00, 16'd2, 8'h80);
        sendResp(8'h01);
        repeat (3) cycle();
        checkOutput("stallBusy", 32'(busy), 32'd1);
        sendResp(8'h01);
        waitDone(4);
        checkOutput("foldSig", 32'(signature), 32'h81);
        checkOutput("foldPass", 32'(pass), 32'd0);

        // Zero-length run goes straight to CHECK
        applyStimulus(8'h5A, 8'h00, 16'd0, 8'h5A);
        checkOutput("zeroBusy", 32'(busy), 32'd1);
        cycle();
        checkOutput("zeroDone", 32'(done), 32'd1);
        checkOutput("zeroPass", 32'(pass), 32'd1);
        checkOutput("zeroSig", 32'(signature), 32'h5A);

        // Reset mid-run, then restart from seed
        applyStimulus(8'h3C, 8'hB8, 16'd10, 8'h00);
        repeat (3) sendResp(N'($urandom));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstSig", 32'(signature), 32'd0);
        applyStimulus(8'h3C, 8'hB8, 16'd1, 8'h1E);
        checkOutput("restartSig", 32'(signature), 32'h3C);
        sendResp(8'h00);
        waitDone(4);
        checkOutput("restartPass", 32'(pass), 32'd1);

        // Reset wins over start on the same edge
        rst = 1'b1; start = 1'b1;
        cycle();
        rst = 1'b0; start = 1'b0;
        checkOutput("rstPrioBusy", 32'(busy), 32'd0);

        // Start while busy is ignored
        applyStimulus(8'h11, 8'h1D, 16'd3, 8'h00);
        sendResp(8'hA5);
        seed = 8'hFF; num_patterns = 16'd0; start = 1'b1;
        cycle();
        start = 1'b0;
        sendResp(8'h3C);
        checkOutput("ignoreStartBusy", 32'(busy), 32'd1);
        sendResp(8'h0F);
        waitDone(4);

        // Maximum length run: must still be busy after many responses
        applyStimulus(8'h77, 8'hB8, 16'hFFFF, 8'h00);
        repeat (300) sendResp(N'($urandom));
        checkOutput("maxLenBusy", 32'(busy), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;

        // Randomized runs with stalls, stray starts and idle noise
        for (int r = 0; r < 40; r++) begin
            s = N'($urandom);
            p = N'($urandom);
            num = $urandom_range(0, 12);
            respList.delete();
            fin = s;
            for (int k = 0; k < num; k++) begin
                respList.push_back(N'($urandom));
                fin = modelMisr(fin, p, respList[k]);
            end
            wantPass = 1'($urandom);
            g = wantPass ? fin : (fin ^ (N'(1) << $urandom_range(0, N - 1)));
            applyStimulus(s, p, 16'(num), g);
            for (int k = 0; k < num; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    start = 1'($urandom_range(0, 3) == 0);
                    cycle();
                    start = 1'b0;
                end
                sendResp(respList[k]);
            end
            waitDone(6);
            checkOutput("randSig", 32'(signature), 32'(fin));
            checkOutput("randPass", 32'(pass), 32'(wantPass));
            repeat ($urandom_range(0, 2)) begin
                resp = N'($urandom);
                resp_valid = 1'($urandom);
                cycle();
            end
            resp_valid = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
